// File: rtl/ahb_slave_mem_bridge.sv
// AHB-Lite slave turning pipelined address/data phases into single-beat memory requests.
// Zero-latency data phase when memory is ready; stalls via o_hreadyout otherwise.
module ahb_slave_mem_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR       = 32
) (
  input  logic                  i_clk_ahb,
  input  logic                  i_rstn_ahb,
  input  logic                  i_hready,
  input  logic                  i_hmastlock,
  input  logic                  i_htrans,
  input  logic [3:0]            i_hprot,
  input  logic [2:0]            i_hburst,
  input  logic [2:0]            i_hsize,
  input  logic                  i_hwrite,
  input  logic [ADDR-1:0]       i_haddr,
  input  logic [DATA_WIDTH-1:0] i_hwdata,
  input  logic                  i_hselx,
  input  logic                  i_ready,
  input  logic                  i_rd_valid,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_hreadyout,
  output logic                  o_hresp,
  output logic [DATA_WIDTH-1:0] o_hrdata,
  output logic                  o_valid,
  output logic                  o_rd0_wr1,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic [ADDR-1:0]       o_addr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR-1:0]       r_addr;
  logic                  r_wr;
  logic [DATA_WIDTH-1:0] r_hrdata;

  logic                  w_hreadyout;
  logic                  w_done;
  logic                  w_accept;
  logic                  w_unused;

  assign w_unused = ^{i_hmastlock, i_hprot, i_hburst, i_hsize};

  assign w_done   = w_hreadyout & i_hready;
  // Qualifying with our own HREADYOUT keeps a stalled request intact even if HREADY misbehaves.
  assign w_accept = i_hselx & i_htrans & i_hready & w_hreadyout;

  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_wr     <= 1'b0;
      r_hrdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr <= i_haddr;
        r_wr   <= i_hwrite;
      end
      if ((r_state == ST_READ) && w_done) begin
        r_hrdata <= i_rd_data;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hreadyout = 1'b1;
    o_valid     = 1'b0;
    o_addr      = '0;
    o_rd0_wr1   = 1'b0;
    o_wr_data   = '0;
    o_hrdata    = r_hrdata;
    case (r_state)
      ST_WRITE: begin
        o_valid     = 1'b1;
        o_addr      = r_addr;
        o_rd0_wr1   = r_wr;
        o_wr_data   = i_hwdata;
        w_hreadyout = i_ready;
      end
      ST_READ: begin
        o_valid     = 1'b1;
        o_addr      = r_addr;
        o_rd0_wr1   = r_wr;
        w_hreadyout = i_ready & i_rd_valid;
        if (i_rd_valid) begin
          o_hrdata = i_rd_data;
        end
      end
      default: begin
        w_hreadyout = 1'b1;
      end
    endcase
    if (w_accept) begin
      w_state_nxt = i_hwrite ? ST_WRITE : ST_READ;
    end else if (w_done) begin
      w_state_nxt = ST_IDLE;
    end
  end

  assign o_hreadyout = w_hreadyout;
  assign o_hresp     = 1'b0;

endmodule

// File: tb/tb_ahb_slave_mem_bridge.sv
// Scoreboard bench for ahb_slave_mem_bridge: expected requests queued at the address phase,
// popped and compared in the data phase.
module tb_ahb_slave_mem_bridge;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        hsel, htrans, hwrite, hmastlock;
  logic [3:0]  hprot;
  logic [2:0]  hburst, hsize;
  logic [31:0] haddr, hwdata;
  logic        mem_ready, rd_valid, ext_rdy;
  logic [31:0] rd_data;
  logic        hready;
  logic        hreadyout, hresp, valid, rd0_wr1;
  logic [31:0] hrdata, wr_data, addr;

  exp_t sb[$];
  int   tests_run;
  int   tests_failed;

  // Bus HREADY: this slave's HREADYOUT unless another agent stalls the bus.
  assign hready = hreadyout & ext_rdy;

  ahb_slave_mem_bridge #(.DATA_WIDTH(32), .ADDR(32)) dut (
    .i_clk_ahb   (clk),
    .i_rstn_ahb  (rst_n),
    .i_hready    (hready),
    .i_hmastlock (hmastlock),
    .i_htrans    (htrans),
    .i_hprot     (hprot),
    .i_hburst    (hburst),
    .i_hsize     (hsize),
    .i_hwrite    (hwrite),
    .i_haddr     (haddr),
    .i_hwdata    (hwdata),
    .i_hselx     (hsel),
    .i_ready     (mem_ready),
    .i_rd_valid  (rd_valid),
    .i_rd_data   (rd_data),
    .o_hreadyout (hreadyout),
    .o_hresp     (hresp),
    .o_hrdata    (hrdata),
    .o_valid     (valid),
    .o_rd0_wr1   (rd0_wr1),
    .o_wr_data   (wr_data),
    .o_addr      (addr)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_addr(input logic s, input logic t, input logic w, input logic [31:0] a);
    hsel   = s;
    htrans = t;
    hwrite = w;
    haddr  = a;
  endtask

  task automatic test_reset();
    #12;
    tests_run++;
    if ({hreadyout, hresp, valid, rd0_wr1, addr, wr_data, hrdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset_state: rdyout=%b resp=%b valid=%b wr=%b addr=%h wdata=%h rdata=%h, want rdyout=1 rest 0",
               hreadyout, hresp, valid, rd0_wr1, addr, wr_data, hrdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single_write();
    exp_t e;
    drive_addr(1'b1, 1'b1, 1'b1, 32'hA);
    sb.push_back('{addr: 32'hA, wr: 1'b1, data: 32'hAAAAAAAA});
    cyc();
    drive_addr(1'b0, 1'b0, 1'b0, 32'h0);
    e = sb.pop_front();
    hwdata = e.data;
    @(negedge clk);
    tests_run++;
    if ({valid, rd0_wr1, addr, wr_data, hreadyout} !== {1'b1, e.wr, e.addr, e.data, 1'b1}) begin
      tests_failed++;
      $display("FAIL single_write: got v=%b w=%b a=%h d=%h r=%b want v=1 w=%b a=%h d=%h r=1",
               valid, rd0_wr1, addr, wr_data, hreadyout, e.wr, e.addr, e.data);
    end
    cyc();
    hwdata = 32'h0;
    @(negedge clk);
    tests_run++;
    if ({valid, hreadyout, addr} !== {1'b0, 1'b1, 32'h0}) begin
      tests_failed++;
      $display("FAIL single_write_idle: got v=%b r=%b a=%h want v=0 r=1 a=0", valid, hreadyout, addr);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_tab [3];
    logic        w_tab [3];
    logic [31:0] d_tab [3];
    exp_t e;
    a_tab[0] = 32'hA; w_tab[0] = 1'b1; d_tab[0] = 32'hAAAAAAAA;
    a_tab[1] = 32'hB; w_tab[1] = 1'b0; d_tab[1] = 32'hBBBBBBBB;
    a_tab[2] = 32'hC; w_tab[2] = 1'b0; d_tab[2] = 32'hCCCCCCCC;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        drive_addr(1'b1, 1'b1, w_tab[i], a_tab[i]);
        sb.push_back('{addr: a_tab[i], wr: w_tab[i], data: d_tab[i]});
      end else begin
        drive_addr(1'b0, 1'b0, 1'b0, 32'h0);
      end
      if (i > 0) begin
        e = sb.pop_front();
        if (e.wr) begin
          hwdata = e.data; rd_valid = 1'b0;
        end else begin
          hwdata = 32'h0; rd_valid = 1'b1; rd_data = e.data;
        end
        @(negedge clk);
        tests_run++;
        if ({valid, rd0_wr1, addr, hreadyout} !== {1'b1, e.wr, e.addr, 1'b1}) begin
          tests_failed++;
          $display("FAIL b2b_req[%0d]: got v=%b w=%b a=%h r=%b want v=1 w=%b a=%h r=1",
                   i, valid, rd0_wr1, addr, hreadyout, e.wr, e.addr);
        end
        tests_run++;
        if ((e.wr ? wr_data : hrdata) !== e.data) begin
          tests_failed++;
          $display("FAIL b2b_data[%0d]: got %h want %h", i, (e.wr ? wr_data : hrdata), e.data);
        end
      end
      cyc();
    end
    rd_valid = 1'b0;
    rd_data  = 32'h12345678;
    @(negedge clk);
    tests_run++;
    if ({valid, hrdata} !== {1'b0, 32'hCCCCCCCC}) begin
      tests_failed++;
      $display("FAIL b2b_hold: got v=%b rdata=%h want v=0 rdata=cccccccc", valid, hrdata);
    end
    cyc();
  endtask

  task automatic test_bus_stall();
    exp_t e;
    drive_addr(1'b1, 1'b1, 1'b1, 32'hD);
    sb.push_back('{addr: 32'hD, wr: 1'b1, data: 32'hDDDDDDDD});
    cyc();
    e = sb.pop_front();
    hwdata = e.data;
    drive_addr(1'b1, 1'b1, 1'b0, 32'hE);
    ext_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        ext_rdy = 1'b1;
        sb.push_back('{addr: 32'hE, wr: 1'b0, data: 32'hEEEEEEEE});
      end
      @(negedge clk);
      tests_run++;
      if ({valid, rd0_wr1, addr, wr_data} !== {1'b1, e.wr, e.addr, e.data}) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: got v=%b w=%b a=%h d=%h want v=1 w=1 a=%h d=%h",
                 k, valid, rd0_wr1, addr, wr_data, e.addr, e.data);
      end
      cyc();
    end
    drive_addr(1'b0, 1'b0, 1'b0, 32'h0);
    hwdata = 32'h0;
    e = sb.pop_front();
    rd_valid = 1'b1;
    rd_data  = e.data;
    @(negedge clk);
    tests_run++;
    if ({valid, rd0_wr1, addr, hrdata, hreadyout} !== {1'b1, 1'b0, e.addr, e.data, 1'b1}) begin
      tests_failed++;
      $display("FAIL stall_next_read: got v=%b w=%b a=%h rd=%h r=%b want v=1 w=0 a=%h rd=%h r=1",
               valid, rd0_wr1, addr, hrdata, hreadyout, e.addr, e.data);
    end
    cyc();
    rd_valid = 1'b0;
    ext_rdy  = 1'b0;
    drive_addr(1'b1, 1'b1, 1'b1, 32'h77);
    cyc();
    drive_addr(1'b0, 1'b0, 1'b0, 32'h0);
    ext_rdy = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({valid, addr} !== {1'b0, 32'h0}) begin
      tests_failed++;
      $display("FAIL idle_stall_nocapture: got v=%b a=%h want v=0 a=0", valid, addr);
    end
    cyc();
  endtask

  task automatic test_mem_wait();
    exp_t e;
    int   waits;
    logic done;
    drive_addr(1'b1, 1'b1, 1'b1, 32'hF);
    sb.push_back('{addr: 32'hF, wr: 1'b1, data: 32'hFFFFFFFF});
    cyc();
    drive_addr(1'b0, 1'b0, 1'b0, 32'h0);
    e = sb.pop_front();
    hwdata = e.data;
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) mem_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({hreadyout, valid, rd0_wr1, addr, wr_data} !== {(k == 2), 1'b1, 1'b1, e.addr, e.data}) begin
        tests_failed++;
        $display("FAIL mem_wait_write[%0d]: got r=%b v=%b w=%b a=%h d=%h want r=%b v=1 w=1 a=%h d=%h",
                 k, hreadyout, valid, rd0_wr1, addr, wr_data, (k == 2), e.addr, e.data);
      end
      cyc();
    end
    hwdata = 32'h0;
    @(negedge clk);
    tests_run++;
    if (valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mem_wait_write_done: got v=%b want v=0", valid);
    end
    drive_addr(1'b1, 1'b1, 1'b0, 32'h10);
    sb.push_back('{addr: 32'h10, wr: 1'b0, data: 32'h10101010});
    cyc();
    drive_addr(1'b0, 1'b0, 1'b0, 32'h0);
    e = sb.pop_front();
    rd_valid = 1'b0;
    rd_data  = 32'h12345678;
    waits = 0;
    done  = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      if (k == 3) begin
        rd_valid = 1'b1;
        rd_data  = e.data;
      end
      @(negedge clk);
      if (hreadyout) begin
        done = 1'b1;
        tests_run++;
        if ({addr, hrdata} !== {e.addr, e.data}) begin
          tests_failed++;
          $display("FAIL mem_wait_read_data: got a=%h rd=%h want a=%h rd=%h", addr, hrdata, e.addr, e.data);
        end
      end else begin
        waits++;
        if (k == 0) begin
          tests_run++;
          if (hrdata !== 32'hEEEEEEEE) begin
            tests_failed++;
            $display("FAIL mem_wait_read_hold: got rd=%h want eeeeeeee", hrdata);
          end
        end
      end
      cyc();
    end
    rd_valid = 1'b0;
    tests_run++;
    if (waits !== 3) begin
      tests_failed++;
      $display("FAIL mem_wait_read_count: got %0d wait states want 3", waits);
    end
  endtask

  task automatic test_deselect();
    exp_t e;
    drive_addr(1'b1, 1'b1, 1'b1, 32'h20);
    sb.push_back('{addr: 32'h20, wr: 1'b1, data: 32'h20202020});
    cyc();
    e = sb.pop_front();
    hwdata = e.data;
    drive_addr(1'b0, 1'b0, 1'b0, 32'h30);
    @(negedge clk);
    tests_run++;
    if ({valid, addr, wr_data, hresp} !== {1'b1, e.addr, e.data, 1'b0}) begin
      tests_failed++;
      $display("FAIL deselect_last: got v=%b a=%h d=%h resp=%b want v=1 a=%h d=%h resp=0",
               valid, addr, wr_data, hresp, e.addr, e.data);
    end
    cyc();
    hwdata = 32'h0;
    drive_addr(1'b1, 1'b0, 1'b1, 32'h31);
    @(negedge clk);
    tests_run++;
    if ({valid, addr, hresp, hreadyout} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL deselect_idle: got v=%b a=%h resp=%b r=%b want v=0 a=0 resp=0 r=1",
               valid, addr, hresp, hreadyout);
    end
    cyc();
    drive_addr(1'b0, 1'b1, 1'b1, 32'h32);
    @(negedge clk);
    tests_run++;
    if ({valid, addr} !== {1'b0, 32'h0}) begin
      tests_failed++;
      $display("FAIL idle_htrans0: got v=%b a=%h want v=0 a=0", valid, addr);
    end
    cyc();
    drive_addr(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    tests_run++;
    if ({valid, addr, hresp} !== {1'b0, 32'h0, 1'b0}) begin
      tests_failed++;
      $display("FAIL idle_hsel0: got v=%b a=%h resp=%b want v=0 a=0 resp=0", valid, addr, hresp);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    drive_addr(1'b1, 1'b1, 1'b0, 32'h40);
    sb.push_back('{addr: 32'h40, wr: 1'b0, data: 32'h40404040});
    cyc();
    drive_addr(1'b0, 1'b0, 1'b0, 32'h0);
    e = sb.pop_front();
    rd_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({valid, hreadyout, addr, hrdata} !== {1'b1, 1'b0, e.addr, 32'h10101010}) begin
      tests_failed++;
      $display("FAIL reset_mid_pre: got v=%b r=%b a=%h rd=%h want v=1 r=0 a=%h rd=10101010",
               valid, hreadyout, addr, hrdata, e.addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({hreadyout, hresp, valid, rd0_wr1, addr, wr_data, hrdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset_mid: rdyout=%b resp=%b valid=%b wr=%b addr=%h wdata=%h rdata=%h, want rdyout=1 rest 0",
               hreadyout, hresp, valid, rd0_wr1, addr, wr_data, hrdata);
    end
    cyc();
    rst_n    = 1'b1;
    rd_valid = 1'b1;
    rd_data  = e.data;
    cyc();
    @(negedge clk);
    tests_run++;
    if ({valid, hrdata} !== {1'b0, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset_mid_abandoned: got v=%b rd=%h want v=0 rd=0", valid, hrdata);
    end
    rd_valid = 1'b0;
    cyc();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    clk       = 1'b0;
    rst_n     = 1'b0;
    hsel      = 1'b0;
    htrans    = 1'b0;
    hwrite    = 1'b0;
    haddr     = 32'h0;
    hwdata    = 32'h0;
    hmastlock = 1'b0;
    hprot     = 4'h3;
    hburst    = 3'h0;
    hsize     = 3'h2;
    mem_ready = 1'b1;
    rd_valid  = 1'b0;
    rd_data   = 32'h0;
    ext_rdy   = 1'b1;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_bus_stall();
    test_mem_wait();
    test_deselect();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ahb_slave_mem_bridge.md
Name: ahb_slave_mem_bridge

Overview:
AHB-Lite slave that converts pipelined AHB transfers into a simple single-beat memory request interface (valid / rd0_wr1 / addr / wr_data, with ready / rd_valid / rd_data back).
- Sits between the AHB interconnect/mux and a local memory or register block.
- Handles the AHB address-phase/data-phase pipeline, including back-to-back transfers and wait states.

Parameters:
- DATA_WIDTH, 32, width of HWDATA/HRDATA and memory data buses.
- ADDR, 32, width of HADDR and memory address bus.

Ports:
- i_clk_ahb  in  1  AHB clock (HCLK); all state on rising edge.
- i_rstn_ahb  in  1  reset; asynchronous, active-low.
- i_hready  in  1  bus-wide HREADY; previous transfer completes and a new address phase is accepted only when 1.
- i_hmastlock  in  1  locked transfer; accepted, ignored.
- i_htrans  in  1  1 = active (NONSEQ) transfer, 0 = IDLE.
- i_hprot  in  4  protection; ignored.
- i_hburst  in  3  burst type; ignored, every beat handled as SINGLE.
- i_hsize  in  3  transfer size; ignored, full word always.
- i_hwrite  in  1  1 = write, 0 = read.
- i_haddr  in  ADDR  transfer address.
- i_hwdata  in  DATA_WIDTH  write data, valid in the data phase.
- i_hselx  in  1  slave select.
- i_ready  in  1  memory accepts the current request.
- i_rd_valid  in  1  memory read data valid.
- i_rd_data  in  DATA_WIDTH  memory read data.
- o_hreadyout  out  1  slave HREADYOUT; 0 inserts wait states.
- o_hresp  out  1  response; constant 0 (OKAY).
- o_hrdata  out  DATA_WIDTH  read data to AHB.
- o_valid  out  1  memory request valid.
- o_rd0_wr1  out  1  request type: 0 = read, 1 = write.
- o_wr_data  out  DATA_WIDTH  write data to memory.
- o_addr  out  ADDR  request address.

Behaviour:
- Accept condition: transfer accepted at a rising edge when i_hselx=1, i_htrans=1 and i_hready=1.
  - Registers i_haddr into addr_q and i_hwrite into wr_q.
  - State moves to WRITE or READ (data phase).
  - Otherwise, when the current data phase completes, state returns to IDLE.
- States:
  - IDLE: no data phase pending.
  - WRITE / READ: data phase of the captured transfer.
  - Data phase completes at the edge where o_hreadyout=1 and i_hready=1; a new transfer may be accepted at that same edge (back-to-back pipelining, no bubble).
- Memory side in WRITE/READ:
  - o_valid=1, o_addr=addr_q, o_rd0_wr1=wr_q.
  - o_wr_data = i_hwdata combinationally in WRITE; holds 0 otherwise.
  - In IDLE: o_valid=0, o_addr=0, o_rd0_wr1=0.
- o_hreadyout:
  - 1 in IDLE.
  - WRITE: equals i_ready.
  - READ: equals i_ready & i_rd_valid.
  - Stalling extends the data phase; o_valid, o_addr, o_rd0_wr1 stay stable until completion.
- o_hrdata:
  - Equals i_rd_data combinationally in READ when i_rd_valid=1.
  - Otherwise holds the last value returned, via a register loaded at each completed read.
- o_hresp is tied to 0; no error responses are generated.
- i_hready=0 from another slave while in IDLE: no capture; address/control must be re-sampled later.
- i_hselx=0 or i_htrans=0 at the completing edge: go to IDLE.
- Reset (async, any state): state=IDLE, addr_q=0, wr_q=0, hrdata register=0.
  - Outputs: o_hreadyout=1, o_hresp=0, o_valid=0, o_rd0_wr1=0, o_addr=0, o_wr_data=0, o_hrdata=0.
  - Reset mid-transfer abandons the request with no completion.

Test Plan:
- Reset: assert i_rstn_ahb low mid-cycle -> all outputs zero immediately, o_hreadyout=1.
- Single write:
  - Stimulus: sel=1, htrans=1, hwrite=1, haddr=0xA, clock edge; then hwdata=0xAAAAAAAA.
  - Response: o_valid=1, o_rd0_wr1=1, o_addr=0xA, o_wr_data=0xAAAAAAAA, o_hreadyout=1.
- Back-to-back write->read->read:
  - Stimulus: addresses 0xA (W), 0xB (R), 0xC (R) on consecutive cycles; i_rd_valid=1 with rd_data 0xBBBBBBBB then 0xCCCCCCCC.
  - Response: o_hrdata shows 0xBBBBBBBB in B's data phase and 0xCCCCCCCC in C's; o_addr steps A, B, C.
- Bus stall:
  - Stimulus: write to 0xD with hwdata=0xDDDDDDDD, i_hready=0 for 2 cycles.
  - Response: no new capture; o_addr stays 0xD, o_wr_data=0xDDDDDDDD until i_hready=1.
- Memory wait:
  - Stimulus: i_ready=0 during a write data phase.
  - Response: o_hreadyout=0, request held; i_ready=1 -> completes next edge.
  - Stimulus: read with i_rd_valid low for 3 cycles.
  - Response: 3 wait states.
- Deselect:
  - Stimulus: i_hselx=0, htrans=0 after the last transfer.
  - Response: returns to IDLE, o_valid=0, o_hresp stays 0 throughout.
